sram_rr_arbiter: RTL

//  Two-port round-robin arbiter/controller sharing the single-port sram between requesters.

---
 rtl/sram_rr_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/sram_rr_arbiter.sv
// sram_rr_arbiter: two-port round-robin arbiter in front of a single-port sram.
// Each accepted request makes exactly one sram access. Reads return on the
// shared rdata bus, qualified by the issuing port's rvalid pulse.
// Optional build macro SRAM_ARB_STATS_EN adds saturating per-port grant counters
// (p0_grants / p1_grants).

`ifdef SRAM_ARB_STATS_EN
// Per-port grant counter: counts acks, saturates at all-ones, clears on rst.
module sram_arb_grant_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [15:0] cnt
);
  // Saturating increment on every ack.
  always_ff @(posedge clk) begin
    if (rst)                          cnt <= '0;
    else if (inc && (cnt != 16'hFFFF)) cnt <= cnt + 16'd1;
  end
endmodule
`endif

module sram_rr_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_wr,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic              p0_rvalid,
  input  logic              p1_req,
  input  logic              p1_wr,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              sram_en,
  output logic              sram_wr,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_din,
  input  logic [DATA_W-1:0] sram_dout
`ifdef SRAM_ARB_STATS_EN
  ,
  output logic [15:0]       p0_grants,
  output logic [15:0]       p1_grants
`endif
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_t            state, state_nxt;
  req_t [1:0]        req_in;
  logic [1:0]        req_vld;
  logic [1:0]        ack_v;
  logic [1:0]        rvalid_v;
  logic              grant;
  logic              win_id;
  logic              win_q;   // port that owns the access in flight
  logic              rr_ptr;  // port with priority when both request
  logic [DATA_W-1:0] rdata_q;

  assign req_in[0] = {p0_wr, p0_addr, p0_wdata};
  assign req_in[1] = {p1_wr, p1_addr, p1_wdata};
  assign req_vld   = {p1_req, p0_req};

  assign p0_ack    = ack_v[0];
  assign p1_ack    = ack_v[1];
  assign p0_rvalid = rvalid_v[0];
  assign p1_rvalid = rvalid_v[1];

  // sram_dout is only valid during RESP, so it is passed through in that cycle
  // to meet the accept+2 latency; rdata_q keeps it until the next read.
  assign rdata = (state == RESP && !rst) ? sram_dout : rdata_q;

  // Arbitration, handshake pulses and next state; rst masks every pulse.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    win_id    = rr_ptr;
    ack_v     = 2'b00;
    rvalid_v  = 2'b00;
    case (state)
      IDLE: begin
        if (|req_vld) begin
          grant         = 1'b1;
          win_id        = (req_vld == 2'b11) ? rr_ptr : req_vld[1];
          ack_v[win_id] = 1'b1;
          state_nxt     = ACCESS;
        end
      end
      ACCESS:  state_nxt = sram_wr ? IDLE : RESP;
      RESP: begin
        rvalid_v[win_q] = 1'b1;
        state_nxt       = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (rst) begin
      grant     = 1'b0;
      ack_v     = 2'b00;
      rvalid_v  = 2'b00;
      state_nxt = IDLE;
    end
  end

  // State, round-robin pointer, sram strobes and the read data holding register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= 1'b0;
      win_q     <= 1'b0;
      sram_en   <= 1'b0;
      sram_wr   <= 1'b0;
      sram_addr <= '0;
      sram_din  <= '0;
      rdata_q   <= '0;
    end else begin
      state   <= state_nxt;
      // Strobes are registered from the accept, so they are high only in ACCESS.
      sram_en <= grant;
      sram_wr <= grant & req_in[win_id].wr;
      if (grant) begin
        win_q     <= win_id;
        rr_ptr    <= ~win_id;
        sram_addr <= req_in[win_id].addr;
        sram_din  <= req_in[win_id].wdata;
      end
      if (state == RESP) rdata_q <= sram_dout;
    end
  end

`ifdef SRAM_ARB_STATS_EN
  logic [1:0][15:0] grants;

  for (genvar i = 0; i < 2; i++) begin : g_cnt
    sram_arb_grant_cnt u_cnt (
      .clk (clk),
      .rst (rst),
      .inc (ack_v[i]),
      .cnt (grants[i])
    );
  end

  assign p0_grants = grants[0];
  assign p1_grants = grants[1];
`endif

endmodule
